uart_avs_responder: RTL and testbench
=====================================

Name: uart_avs_responder

Overview:
- Avalon-MM slave UART that answers the RS232 register protocol our wrapper masters issue on avm_address/avm_read/avm_write/avm_waitrequest.
- Serialises written bytes onto UART_TXD and deserialises UART_RXD into a readable data register, with a status word the master polls.
- Sits between the board's UART pins and any wrapper that acts as the Avalon master.
- Lets us replace the Qsys-generated UART with in-house RTL and simulate master and responder together.

Parameters:
CLK_HZ, 25_000_000, frequency of avm_clk in Hz.
BAUD, 115_200, serial bit rate. DIV = CLK_HZ/BAUD, integer-truncated, 217 at the defaults.

Ports:
avm_clk  in  1  system clock (25 MHz domain)
avm_rst  in  1  reset, asynchronous, active-low
avs_address  in  5  byte address: 0 = RXDATA, 4 = TXDATA, 8 = STATUS
avs_read  in  1  read request
avs_readdata  out  32  read data, registered
avs_write  in  1  write request
avs_writedata  in  32  write data; bits [7:0] used
avs_waitrequest  out  1  high = transfer not yet accepted
uart_rxd  in  1  serial input, asynchronous
uart_txd  out  1  serial output, idle high

Behaviour:
- Reset values (while avm_rst = 0):
  - uart_txd = 1, avs_readdata = 0, avs_waitrequest = 1.
  - RRDY = 0, TRDY = 1, TMT = 1, FE = ROE = TOE = 0.
  - RX and TX FSMs return to IDLE.
- Reset mid-frame aborts the frame. After release, RX waits for a fresh falling edge.
- Bus handshake uses a fixed one wait state, driven by an ack flop:
  - avs_waitrequest = ~ack.
  - Cycle N: read or write seen with ack = 0 -> ack = 1 at N+1.
  - Cycle N+1: transfer completes, avs_readdata is valid, side effects fire exactly once.
  - Cycle N+2: ack returns to 0.
  - Back-to-back transfers therefore take 2 cycles each.
  - read and write asserted together: the read is honoured and the write is ignored.
- Register map (read data is zero-extended to 32 bits):
  - RXDATA read: returns {24'b0, rx_byte} and clears RRDY.
  - TXDATA write: if TRDY = 1, loads the holding register and clears TRDY. If TRDY = 0, data is dropped and TOE is set.
  - STATUS read bits [7:0]: RRDY[7], TRDY[6], TMT[5], TOE[4], ROE[3], 0[2], FE[1], 0[0]. Bits [31:8] read 0.
  - STATUS write: clears FE, ROE and TOE; data is ignored.
  - Any other address: reads return 0, writes have no effect.
- TX FSM (IDLE -> START -> DATA -> STOP):
  - In IDLE with TRDY = 0: next cycle, holding register -> shifter, TRDY = 1, TMT = 0, go to START.
  - Each bit lasts DIV cycles. Data is sent LSB first, 8 bits, then 1 stop bit (8N1).
  - At the end of STOP: if holding is full, go straight to START with no idle gap; otherwise go to IDLE and set TMT = 1.
- RX FSM (IDLE -> START -> DATA -> STOP):
  - uart_rxd passes through a 2-flop synchroniser.
  - A falling edge in IDLE starts counting. After DIV/2 cycles (108), the line is re-sampled: if high, treat as a glitch and return to IDLE; if low, go to DATA.
  - Bits are sampled every DIV cycles thereafter, LSB first.
  - At stop-bit sample time, with stop bit = 0: set FE and discard the byte. RRDY is unchanged.
  - With stop bit = 1: store the byte. If RRDY is already 1, set ROE and overwrite. Then set RRDY = 1.
  - Frame completion and an RXDATA-read completion in the same cycle: the new byte wins, RRDY stays 1, no ROE.
- All counters are sized to ceil(log2(DIV)) bits and wrap only under FSM control.

Decomposition:
- Package uart_avs_pkg holds:
  - address localparams RX_OFS = 5'd0, TX_OFS = 5'd4, STAT_OFS = 5'd8;
  - status bit indices RRDY_BIT = 7, TRDY_BIT = 6, TMT_BIT = 5, TOE_BIT = 4, ROE_BIT = 3, FE_BIT = 1;
  - the shared enum typedef uart_state_t {IDLE, START, DATA, STOP}.
- One sub-module, uart_rx_deser, contains the synchroniser, RX FSM and bit counter. It outputs a 1-cycle byte_valid with the byte, and a 1-cycle frame_err.
- TX logic, the register file and the Avalon handshake stay in the top module.

Test Plan:
- Reset release, then STATUS read -> waitrequest high 1 cycle, readdata = 32'h60 (TRDY | TMT), uart_txd = 1.
- Write TXDATA = 8'hA5 -> uart_txd frame: 0, 1,0,1,0,0,1,0,1, 1, each bit 217 cycles; TMT = 0 during the frame, STATUS = 32'h60 after the stop bit.
- Drive an 8N1 frame of 8'h3C on uart_rxd -> STATUS bit 7 = 1; RXDATA read returns 32'h3C; following STATUS read has bit 7 = 0.
- Two RX frames, 8'h11 then 8'h22, with no read between -> STATUS = 32'hE8 (RRDY, TRDY, TMT, ROE); RXDATA = 32'h22; STATUS write, then STATUS read = 32'h60.
- RX frame with stop bit = 0 -> FE set (STATUS = 32'h62), RRDY stays 0. Separately, a 50-cycle low glitch -> no state change.
- Write TXDATA twice back-to-back during an active frame, then a third write while TRDY = 0 -> two frames with no idle gap, third byte never sent, TOE set (STATUS bit 4 = 1).

Source files
------------

// File: rtl/uart_avs_pkg.sv
// Shared definitions for the Avalon-MM UART responder: register offsets,
// STATUS bit positions, the common serial FSM state type and a divider helper.
// Latency: n/a (package). Backpressure: n/a.
package uart_avs_pkg;

   // Byte addresses of the register map.
   localparam logic [4:0] RX_OFS   = 5'd0;
   localparam logic [4:0] TX_OFS   = 5'd4;
   localparam logic [4:0] STAT_OFS = 5'd8;

   // STATUS word bit positions; bits 2 and 0 are reserved and read as zero.
   localparam int RRDY_BIT = 7;
   localparam int TRDY_BIT = 6;
   localparam int TMT_BIT  = 5;
   localparam int TOE_BIT  = 4;
   localparam int ROE_BIT  = 3;
   localparam int FE_BIT   = 1;

   // Both serial engines walk the same four phases of an 8N1 frame.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   // Clock cycles per serial bit, integer-truncated.
   function automatic int baud_div(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_rx_deser.sv
// Purpose: synchronises uart_rxd, finds start bits and deserialises 8N1 frames.
// Latency: byte_valid/frame_err pulse one cycle after the mid-stop-bit sample.
// Backpressure: none; the consumer must take each byte_valid pulse as it comes.
// Ports: clk, rst_n (async active-low), rxd (async serial in),
//        rx_byte (last deserialised byte), byte_valid, frame_err (1-cycle pulses).
module uart_rx_deser
   import uart_avs_pkg::*;
#(
   parameter int DIV = 217
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);
   localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);

   logic          rxd_meta;
   logic          rxd_sync;
   logic          rxd_prev;
   uart_state_t   state;
   uart_state_t   state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic [2:0]    bit_idx;
   logic [2:0]    bit_nxt;
   logic          shift_en;
   logic          valid_nxt;
   logic          ferr_nxt;
   logic [7:0]    shreg;

   // The synchroniser and edge history reset low so that a line already low
   // at reset release cannot look like a falling edge: RX only starts after
   // it has seen the line high and then low again.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxd_meta <= 1'b0;
         rxd_sync <= 1'b0;
         rxd_prev <= 1'b0;
      end else begin
         rxd_meta <= rxd;
         rxd_sync <= rxd_meta;
         rxd_prev <= rxd_sync;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 1'b1;
      bit_nxt   = bit_idx;
      shift_en  = 1'b0;
      valid_nxt = 1'b0;
      ferr_nxt  = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (rxd_prev && !rxd_sync) begin
               state_nxt = START;
            end
         end
         START: begin
            // Mid-start-bit check: a line back high means the edge was a glitch.
            if (cnt == HALF_END) begin
               cnt_nxt   = '0;
               bit_nxt   = '0;
               state_nxt = rxd_sync ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == BIT_END) begin
               cnt_nxt  = '0;
               shift_en = 1'b1;
               bit_nxt  = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
                  state_nxt = STOP;
               end
            end
         end
         STOP: begin
            if (cnt == BIT_END) begin
               cnt_nxt   = '0;
               state_nxt = IDLE;
               valid_nxt = rxd_sync;
               ferr_nxt  = !rxd_sync;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         cnt        <= cnt_nxt;
         bit_idx    <= bit_nxt;
         byte_valid <= valid_nxt;
         frame_err  <= ferr_nxt;
         // LSB arrives first, so shift in from the top.
         if (shift_en) begin
            shreg <= {rxd_sync, shreg[7:1]};
         end
      end
   end

   assign rx_byte = shreg;

endmodule

// File: rtl/uart_avs_responder.sv
// Purpose: Avalon-MM slave UART (RXDATA/TXDATA/STATUS) with 8N1 TX serialiser.
// Latency: fixed one wait state; readdata valid and side effects in cycle N+1.
// Backpressure: waitrequest = ~ack; TX writes with TRDY=0 are dropped and set TOE.
// Ports: avm_clk, avm_rst (async active-low), avs_address/read/readdata/write/
//        writedata/waitrequest (Avalon-MM slave), uart_rxd (async in), uart_txd.
module uart_avs_responder
   import uart_avs_pkg::*;
#(
   parameter int CLK_HZ = 25_000_000,
   parameter int BAUD   = 115_200
) (
   input  logic        avm_clk,
   input  logic        avm_rst,
   input  logic [4:0]  avs_address,
   input  logic        avs_read,
   output logic [31:0] avs_readdata,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   output logic        avs_waitrequest,
   input  logic        uart_rxd,
   output logic        uart_txd
);

   localparam int            DIV     = baud_div(CLK_HZ, BAUD);
   localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] BIT_END = CW'(DIV - 1);

   // Bus handshake
   logic        ack;
   logic        rd_fire;
   logic        wr_fire;
   logic [31:0] rd_mux;
   logic [7:0]  status;
   logic        unused_wdata;

   // Register file
   logic       rrdy;
   logic       roe;
   logic       fe;
   logic       trdy;
   logic       tmt;
   logic       toe;
   logic [7:0] rx_data;
   logic [7:0] tx_hold;

   // RX engine
   logic [7:0] rx_byte;
   logic       byte_valid;
   logic       frame_err;

   // TX engine
   uart_state_t   tx_state;
   uart_state_t   tx_state_nxt;
   logic [CW-1:0] tx_cnt;
   logic [CW-1:0] tx_cnt_nxt;
   logic [2:0]    tx_bit;
   logic [2:0]    tx_bit_nxt;
   logic [7:0]    tx_shreg;
   logic          tx_load;
   logic          tx_shift;
   logic          tx_done;
   logic          txd_nxt;

   assign unused_wdata = ^avs_writedata[31:8];

   // ---------------------------------------------------------------- bus
   // Every transfer gets exactly one wait state; ack is high for one cycle
   // and then forced low so back-to-back requests are never merged.
   always_ff @(posedge avm_clk or negedge avm_rst) begin
      if (!avm_rst) begin
         ack <= 1'b0;
      end else begin
         ack <= !ack && (avs_read || avs_write);
      end
   end

   assign avs_waitrequest = !ack;
   assign rd_fire         = ack && avs_read;
   // A simultaneous read wins; the write is discarded.
   assign wr_fire         = ack && avs_write && !avs_read;

   always_comb begin
      status           = '0;
      status[RRDY_BIT] = rrdy;
      status[TRDY_BIT] = trdy;
      status[TMT_BIT]  = tmt;
      status[TOE_BIT]  = toe;
      status[ROE_BIT]  = roe;
      status[FE_BIT]   = fe;
   end

   always_comb begin
      rd_mux = '0;
      case (avs_address)
         RX_OFS:   rd_mux = {24'd0, rx_data};
         STAT_OFS: rd_mux = {24'd0, status};
         default:  rd_mux = '0;
      endcase
   end

   // Capture read data in the wait-state cycle so it is valid while ack is high.
   always_ff @(posedge avm_clk or negedge avm_rst) begin
      if (!avm_rst) begin
         avs_readdata <= '0;
      end else if (!ack && avs_read) begin
         avs_readdata <= rd_mux;
      end
   end

   // ---------------------------------------------------------------- RX
   uart_rx_deser #(
      .DIV (DIV)
   ) u_rx (
      .clk        (avm_clk),
      .rst_n      (avm_rst),
      .rxd        (uart_rxd),
      .rx_byte    (rx_byte),
      .byte_valid (byte_valid),
      .frame_err  (frame_err)
   );

   // Clears are placed ahead of sets so a new event in the same cycle as a
   // STATUS write or RXDATA read is never lost.
   always_ff @(posedge avm_clk or negedge avm_rst) begin
      if (!avm_rst) begin
         rrdy    <= 1'b0;
         roe     <= 1'b0;
         fe      <= 1'b0;
         rx_data <= '0;
      end else begin
         if (wr_fire && avs_address == STAT_OFS) begin
            fe  <= 1'b0;
            roe <= 1'b0;
         end
         if (rd_fire && avs_address == RX_OFS) begin
            rrdy <= 1'b0;
         end
         if (frame_err) begin
            fe <= 1'b1;
         end
         if (byte_valid) begin
            rx_data <= rx_byte;
            rrdy    <= 1'b1;
            // Data being read out in this very cycle is not an overrun.
            if (rrdy && !(rd_fire && avs_address == RX_OFS)) begin
               roe <= 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------- TX
   always_ff @(posedge avm_clk or negedge avm_rst) begin
      if (!avm_rst) begin
         tx_state <= IDLE;
      end else begin
         tx_state <= tx_state_nxt;
      end
   end

   always_comb begin
      tx_state_nxt = tx_state;
      tx_cnt_nxt   = tx_cnt + 1'b1;
      tx_bit_nxt   = tx_bit;
      tx_load      = 1'b0;
      tx_shift     = 1'b0;
      tx_done      = 1'b0;
      txd_nxt      = 1'b1;
      case (tx_state)
         IDLE: begin
            tx_cnt_nxt = '0;
            if (!trdy) begin
               tx_load      = 1'b1;
               tx_state_nxt = START;
            end
         end
         START: begin
            txd_nxt = 1'b0;
            if (tx_cnt == BIT_END) begin
               tx_cnt_nxt   = '0;
               tx_bit_nxt   = '0;
               tx_state_nxt = DATA;
            end
         end
         DATA: begin
            txd_nxt = tx_shreg[0];
            if (tx_cnt == BIT_END) begin
               tx_cnt_nxt = '0;
               tx_shift   = 1'b1;
               tx_bit_nxt = tx_bit + 3'd1;
               if (tx_bit == 3'd7) begin
                  tx_state_nxt = STOP;
               end
            end
         end
         STOP: begin
            txd_nxt = 1'b1;
            if (tx_cnt == BIT_END) begin
               tx_cnt_nxt = '0;
               // A byte already waiting in the holding register follows
               // immediately, without an idle bit between frames.
               if (!trdy) begin
                  tx_load      = 1'b1;
                  tx_state_nxt = START;
               end else begin
                  tx_done      = 1'b1;
                  tx_state_nxt = IDLE;
               end
            end
         end
         default: begin
            tx_state_nxt = IDLE;
         end
      endcase
   end

   // tx_load only fires with TRDY low and a TXDATA write is only accepted
   // with TRDY high, so the two TRDY updates can never collide.
   always_ff @(posedge avm_clk or negedge avm_rst) begin
      if (!avm_rst) begin
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shreg <= '0;
         tx_hold  <= '0;
         trdy     <= 1'b1;
         tmt      <= 1'b1;
         toe      <= 1'b0;
         uart_txd <= 1'b1;
      end else begin
         tx_cnt   <= tx_cnt_nxt;
         tx_bit   <= tx_bit_nxt;
         uart_txd <= txd_nxt;
         if (tx_load) begin
            tx_shreg <= tx_hold;
            trdy     <= 1'b1;
            tmt      <= 1'b0;
         end else if (tx_shift) begin
            tx_shreg <= {1'b0, tx_shreg[7:1]};
         end
         if (tx_done) begin
            tmt <= 1'b1;
         end
         if (wr_fire && avs_address == STAT_OFS) begin
            toe <= 1'b0;
         end
         if (wr_fire && avs_address == TX_OFS) begin
            if (trdy) begin
               tx_hold <= avs_writedata[7:0];
               trdy    <= 1'b0;
            end else begin
               toe <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_avs_responder.sv
// Purpose: bench for uart_avs_responder; reads and TX frames are checked by
// independent monitors against queues filled by the stimulus and a flag model.
// Ports: none (top-level bench).
module tb_uart_avs_responder;

   localparam int CLK_HZ = 25_000_000;
   localparam int BAUD   = 115_200;
   localparam int DIV    = CLK_HZ / BAUD;

   logic        avm_clk = 1'b0;
   logic        avm_rst = 1'b0;
   logic [4:0]  avs_address = '0;
   logic        avs_read = 1'b0;
   logic [31:0] avs_readdata;
   logic        avs_write = 1'b0;
   logic [31:0] avs_writedata = '0;
   logic        avs_waitrequest;
   logic        uart_rxd = 1'b1;
   logic        uart_txd;

   uart_avs_responder #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD)
   ) dut (
      .avm_clk         (avm_clk),
      .avm_rst         (avm_rst),
      .avs_address     (avs_address),
      .avs_read        (avs_read),
      .avs_readdata    (avs_readdata),
      .avs_write       (avs_write),
      .avs_writedata   (avs_writedata),
      .avs_waitrequest (avs_waitrequest),
      .uart_rxd        (uart_rxd),
      .uart_txd        (uart_txd)
   );

   always #20 avm_clk = ~avm_clk;

   int cyc = 0;
   always @(posedge avm_clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] b;
      bit         b2b;
   } tx_exp_t;

   logic [31:0] rd_q[$];
   tx_exp_t     tx_q[$];

   // Reference model of the sticky register state.
   bit         m_rrdy = 0;
   bit         m_roe  = 0;
   bit         m_fe   = 0;
   bit         m_toe  = 0;
   logic [7:0] m_rx   = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] stat_exp(input bit trdy, input bit tmt);
      logic [31:0] s;
      s = '0;
      s[7] = m_rrdy;
      s[6] = trdy;
      s[5] = tmt;
      s[4] = m_toe;
      s[3] = m_roe;
      s[1] = m_fe;
      return s;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge avm_clk);
      #1;
   endtask

   // Counts cycles with waitrequest high before acceptance; must be exactly one.
   task automatic wait_ack(input string name);
      int n;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge avm_clk);
         if (!avs_waitrequest) break;
         n++;
      end
      check(name, n, 1);
   endtask

   task automatic bus_read(input logic [4:0] a, input logic [31:0] exp);
      rd_q.push_back(exp);
      avs_address = a;
      avs_read    = 1'b1;
      wait_ack("rd_wait_states");
      @(posedge avm_clk);
      #1;
      avs_read = 1'b0;
   endtask

   task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input bit hold);
      avs_address   = a;
      avs_writedata = d;
      avs_write     = 1'b1;
      wait_ack("wr_wait_states");
      @(posedge avm_clk);
      #1;
      if (!hold) avs_write = 1'b0;
   endtask

   task automatic rd_status();
      bus_read(5'd8, stat_exp(1, 1));
   endtask

   task automatic rd_rx();
      bus_read(5'd0, {24'd0, m_rx});
      m_rrdy = 0;
   endtask

   task automatic wr_status();
      bus_write(5'd8, $urandom, 0);
      m_fe  = 0;
      m_roe = 0;
      m_toe = 0;
   endtask

   // Read and write together on STATUS: read returns flags, write must not clear them.
   task automatic rw_status();
      rd_q.push_back(stat_exp(1, 1));
      avs_address   = 5'd8;
      avs_writedata = $urandom;
      avs_read      = 1'b1;
      avs_write     = 1'b1;
      wait_ack("rw_wait_states");
      @(posedge avm_clk);
      #1;
      avs_read  = 1'b0;
      avs_write = 1'b0;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stopb);
      logic [9:0] fr;
      fr = {stopb, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         uart_rxd = fr[i];
         repeat (DIV) @(posedge avm_clk);
         #1;
      end
      uart_rxd = 1'b1;
      idle(20);
      if (stopb) begin
         if (m_rrdy) m_roe = 1;
         m_rx   = b;
         m_rrdy = 1;
      end else begin
         m_fe = 1;
      end
   endtask

   task automatic glitch();
      uart_rxd = 1'b0;
      idle(50);
      uart_rxd = 1'b1;
      idle(200);
   endtask

   // Back-to-back TXDATA writes starting with TX idle: the first two bytes are
   // accepted (shifter + holding register), any further byte overflows.
   task automatic tx_burst(input int k, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2);
      logic [7:0]  bs[3];
      logic [31:0] wd;
      tx_exp_t     e;
      bs[0] = b0;
      bs[1] = b1;
      bs[2] = b2;
      for (int i = 0; i < k; i++) begin
         if (i < 2) begin
            e.b   = bs[i];
            e.b2b = (i == 1);
            tx_q.push_back(e);
         end else begin
            m_toe = 1;
         end
         wd       = $urandom;
         wd[7:0]  = bs[i];
         bus_write(5'd4, wd, i < k - 1);
      end
   endtask

   // Read scoreboard monitor.
   initial begin : rd_mon
      logic [31:0] e;
      forever begin
         @(negedge avm_clk);
         if (avm_rst && avs_read && !avs_waitrequest) begin
            if (rd_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rd_unexpected: got %h expected no read", avs_readdata);
            end else begin
               e = rd_q.pop_front();
               check("readdata", avs_readdata, e);
            end
         end
      end
   end

   // TX line monitor: decodes 8N1 frames sampled mid-bit.
   initial begin : tx_mon
      int         last_start;
      int         t0;
      bit         have_last;
      logic [7:0] got;
      tx_exp_t    e;
      have_last  = 0;
      last_start = 0;
      wait (avm_rst === 1'b1);
      forever begin
         @(negedge avm_clk);
         if (uart_txd === 1'b0) begin
            t0 = cyc;
            repeat (DIV / 2) @(negedge avm_clk);
            check("tx_start_bit", {31'd0, uart_txd}, 32'd0);
            for (int i = 0; i < 8; i++) begin
               repeat (DIV) @(negedge avm_clk);
               got[i] = uart_txd;
            end
            repeat (DIV) @(negedge avm_clk);
            check("tx_stop_bit", {31'd0, uart_txd}, 32'd1);
            if (tx_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL tx_unexpected: got frame %h expected none", got);
            end else begin
               e = tx_q.pop_front();
               check("tx_byte", {24'd0, got}, {24'd0, e.b});
               if (e.b2b && have_last) check("tx_no_gap", t0 - last_start, 10 * DIV);
            end
            last_start = t0;
            have_last  = 1;
         end
      end
   end

   initial begin : stim
      int         k;
      int         op;
      logic [4:0] a;

      // Reset state.
      idle(5);
      check("rst_txd", {31'd0, uart_txd}, 32'd1);
      check("rst_waitrequest", {31'd0, avs_waitrequest}, 32'd1);
      check("rst_readdata", avs_readdata, 32'd0);
      avm_rst = 1'b1;
      idle(5);

      rd_status();

      // Single TX frame; TMT low mid-frame, back after the stop bit.
      tx_burst(1, 8'hA5, 8'h00, 8'h00);
      idle(5 * DIV);
      bus_read(5'd8, stat_exp(1, 0));
      idle(6 * DIV);
      rd_status();

      // Single RX frame.
      send_rx(8'h3C, 1'b1);
      rd_status();
      rd_rx();
      rd_status();

      // Overrun.
      send_rx(8'h11, 1'b1);
      send_rx(8'h22, 1'b1);
      rd_status();
      rd_rx();
      wr_status();
      rd_status();

      // Framing error, read+write priority, glitch rejection.
      send_rx(8'($urandom), 1'b0);
      rd_status();
      rw_status();
      rd_status();
      wr_status();
      glitch();
      rd_status();

      // Two chained frames plus one overflowing write.
      tx_burst(3, 8'h5A, 8'hC3, 8'h0F);
      idle(3 * DIV);
      bus_read(5'd8, stat_exp(0, 0));
      idle(18 * DIV);
      rd_status();
      wr_status();
      rd_status();

      // Randomised operations.
      for (int it = 0; it < 12; it++) begin
         op = $urandom_range(0, 7);
         case (op)
            0: send_rx(8'($urandom), 1'b1);
            1: send_rx(8'($urandom), 1'b0);
            2: glitch();
            3: rd_rx();
            4: rd_status();
            5: wr_status();
            6: begin
               k = $urandom_range(1, 3);
               tx_burst(k, 8'($urandom), 8'($urandom), 8'($urandom));
               idle(((k > 1) ? 2 : 1) * 10 * DIV + 100);
               rd_status();
            end
            default: begin
               a = 5'($urandom_range(3, 7) * 4);
               bus_read(a, 32'd0);
               bus_write(a, $urandom, 0);
               rd_status();
            end
         endcase
      end

      idle(100);
      check("rd_q_drained", rd_q.size(), 0);
      check("tx_q_drained", tx_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
